// File: rtl/from_proj.sv
// from_proj: converts an extended-coordinate curve point (X:Y:Z:T) over
// GF(2^255-19) into affine form, Px = X/Z and Py = Y/Z.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   en     - start request, only taken while idle
//   Rx/Ry/Rz - projective coordinates, each in 0..p-1
//   Rt     - extended T coordinate, present for interface symmetry, unused
//   Px/Py  - affine result, held until the next completion or reset
//   busy   - high while a conversion is in progress
//   done   - one-cycle pulse when Px/Py/err are refreshed
//   err    - set when the last accepted Z was zero (Px = Py = 0 then)
//
// Flow: IDLE -> INV (binary extended Euclid, one step per cycle)
//       -> MULX -> MULY (MSB-first interleaved modular multiply, N cycles
//       each) -> FIN. A zero Z jumps straight from IDLE to FIN.
module from_proj #(
  parameter int N = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] Rx,
  input  logic [N-1:0] Ry,
  input  logic [N-1:0] Rz,
  input  logic [N-1:0] Rt,
  output logic [N-1:0] Px,
  output logic [N-1:0] Py,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int          CW      = $clog2(N);
  localparam logic [N:0]  P       = {1'b0, {N{1'b1}}} - (N+1)'(18);
  localparam logic [N:0]  ONE     = (N+1)'(1);
  localparam logic [CW-1:0] CNT_TOP = CW'(N-1);

  typedef enum logic [2:0] {
    IDLE,
    INV,
    MULX,
    MULY,
    FIN
  } state_t;

  state_t state_q, state_d;

  // Operands and working registers; all field values live in N+1 bits.
  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  y_q, y_d;
  logic [N:0]    u_q, u_d;
  logic [N:0]    v_q, v_d;
  logic [N:0]    x1_q, x1_d;
  logic [N:0]    x2_q, x2_d;
  logic [N:0]    inv_q, inv_d;
  logic [N:0]    acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    pxr_q, pxr_d;
  logic [N:0]    pyr_q, pyr_d;
  logic          zero_q, zero_d;

  // Registered outputs.
  logic [N-1:0]  px_q, px_d;
  logic [N-1:0]  py_q, py_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [N:0]    mul_next;
  logic          mul_bit;

  logic          unused_ok;
  assign unused_ok = ^{Rt, pxr_q[N], pyr_q[N]};

  // a/2 mod p: an odd a becomes even by adding p (a+p < 2p fits in N+1 bits).
  function automatic logic [N:0] half_mod(input logic [N:0] a);
    logic [N:0] t;
    t = a[0] ? a + P : a;
    return t >> 1;
  endfunction

  // (a-b) mod p with a,b in 0..p-1: wrap-around then fold back by +p.
  function automatic logic [N:0] sub_mod(input logic [N:0] a, input logic [N:0] b);
    logic [N:0] d;
    d = a - b;
    if (a < b) d = d + P;
    return d;
  endfunction

  // Single conditional subtraction; input is below 2p.
  function automatic logic [N:0] red_once(input logic [N:0] a);
    return (a >= P) ? a - P : a;
  endfunction

  // One interleaved multiply step: acc = 2*acc mod p, then + a if bit set.
  function automatic logic [N:0] mul_step(input logic [N:0] acc,
                                          input logic [N:0] a,
                                          input logic       b);
    logic [N:0] t;
    t = red_once(acc << 1);
    if (b) t = red_once(t + a);
    return t;
  endfunction

  // The multiplier bit comes from X during MULX and Y during MULY.
  always_comb begin
    mul_bit  = (state_q == MULY) ? y_q[cnt_q] : x_q[cnt_q];
    mul_next = mul_step(acc_q, inv_q, mul_bit);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (en) state_d = (Rz == '0) ? FIN : INV;
      INV:  if (u_q == ONE || v_q == ONE) state_d = MULX;
      MULX: if (cnt_q == '0) state_d = MULY;
      MULY: if (cnt_q == '0) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state logic
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    u_d    = u_q;
    v_d    = v_q;
    x1_d   = x1_q;
    x2_d   = x2_q;
    inv_d  = inv_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    pxr_d  = pxr_q;
    pyr_d  = pyr_q;
    zero_d = zero_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          x_d    = Rx;
          y_d    = Ry;
          u_d    = {1'b0, Rz};
          v_d    = P;
          x1_d   = ONE;
          x2_d   = '0;
          acc_d  = '0;
          pxr_d  = '0;
          pyr_d  = '0;
          zero_d = (Rz == '0);
        end
      end
      INV: begin
        // Invariants: x1*Z == u and x2*Z == v (mod p).
        if (u_q == ONE || v_q == ONE) begin
          inv_d = (u_q == ONE) ? x1_q : x2_q;
          acc_d = '0;
          cnt_d = CNT_TOP;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = half_mod(x1_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = half_mod(x2_q);
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = sub_mod(x1_q, x2_q);
        end else begin
          v_d  = v_q - u_q;
          x2_d = sub_mod(x2_q, x1_q);
        end
      end
      MULX: begin
        if (cnt_q == '0) begin
          pxr_d = mul_next;
          acc_d = '0;
          cnt_d = CNT_TOP;
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q - CW'(1);
        end
      end
      MULY: begin
        if (cnt_q == '0) begin
          pyr_d = mul_next;
          acc_d = '0;
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Output logic: results, done and busy all change on the edge leaving FIN,
  // so the done pulse coincides with the first idle cycle.
  always_comb begin
    px_d   = px_q;
    py_d   = py_q;
    err_d  = err_q;
    done_d = (state_q == FIN);
    busy_d = (state_d != IDLE);
    if (state_q == FIN) begin
      px_d  = pxr_q[N-1:0];
      py_d  = pyr_q[N-1:0];
      err_d = zero_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      u_q    <= '0;
      v_q    <= '0;
      x1_q   <= '0;
      x2_q   <= '0;
      inv_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      pxr_q  <= '0;
      pyr_q  <= '0;
      zero_q <= 1'b0;
      px_q   <= '0;
      py_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      u_q    <= u_d;
      v_q    <= v_d;
      x1_q   <= x1_d;
      x2_q   <= x2_d;
      inv_q  <= inv_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      pxr_q  <= pxr_d;
      pyr_q  <= pyr_d;
      zero_q <= zero_d;
      px_q   <= px_d;
      py_q   <= py_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign Px   = px_q;
  assign Py   = py_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_from_proj.sv
module tb_from_proj;

  localparam int N = 255;
  localparam logic [N-1:0] P = {N{1'b1}} - 255'd18;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [N-1:0] Rx, Ry, Rz, Rt;
  logic [N-1:0] Px, Py;
  logic         busy, done, err;

  from_proj #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .Rx   (Rx),
    .Ry   (Ry),
    .Rz   (Rz),
    .Rt   (Rt),
    .Px   (Px),
    .Py   (Py),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] px;
    logic [N-1:0] py;
    logic         err;
    int           t;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev = 1'b0;
    end else begin
      if (done) begin
        exp_t e;
        int   lat;
        if (done_prev) begin
          total++;
          bad++;
          $display("FAIL done_width: done high for two consecutive cycles");
        end
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want no done at cycle %0d", cyc);
        end else begin
          e   = sb.pop_front();
          lat = cyc - e.t;
          chk("Px", Px, e.px);
          chk("Py", Py, e.py);
          chk("err", N'(err), N'(e.err));
          chk("busy_at_done", N'(busy), '0);
          if (e.zero) chk("latency_zero", N'(lat), N'(2));
          else        chk("latency_bound", N'(lat <= 4*N+6), N'(1));
        end
      end
      done_prev = done;
    end
  end

  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input logic [N-1:0] z,
                       input logic [N-1:0] epx, input logic [N-1:0] epy, input logic eerr);
    @(negedge clk);
    Rx = x; Ry = y; Rz = z; Rt = x ^ y;
    en = 1'b1;
    sb.push_back('{epx, epy, eerr, cyc, (z == '0)});
    @(negedge clk);
    en = 1'b0;
    chk("busy_after_accept", N'(busy), N'(1));
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s: got %0d results pending want 0 (timeout)", nm, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0;
    Rx = '0; Ry = '0; Rz = '0; Rt = '0;
    repeat (3) @(negedge clk);
    chk("rst_Px", Px, '0);
    chk("rst_Py", Py, '0);
    chk("rst_busy", N'(busy), '0);
    chk("rst_done", N'(done), '0);
    chk("rst_err", N'(err), '0);
    rst_n = 1'b1;

    // Neutral point and scaled variants
    issue(255'd0, 255'd1, 255'd1, 255'd0, 255'd1, 1'b0);
    drain("neutral");
    issue(255'd0, 255'd2, 255'd2, 255'd0, 255'd1, 1'b0);
    drain("scaled_neutral");
    issue(255'd2, 255'd4, 255'd2, 255'd1, 255'd2, 1'b0);
    drain("scaled_point");
    issue(255'd5, 255'd7, 255'd1, 255'd5, 255'd7, 1'b0);
    drain("z_one");

    // Z = p-1 = -1: results are -X, -Y
    issue(255'd3, 255'd5, P - 255'd1, P - 255'd3, P - 255'd5, 1'b0);
    drain("z_minus_one");

    // Z = 2: 1/2 = (p+1)/2, 3/2 = (p+3)/2
    issue(255'd1, 255'd3, 255'd2, (P + 255'd1) >> 1, (P + 255'd3) >> 1, 1'b0);
    drain("z_two");

    // Z = 0 sets err with fixed 2-cycle latency; next valid request clears it
    issue(255'd9, 255'd11, 255'd0, 255'd0, 255'd0, 1'b1);
    drain("z_zero");
    issue(255'd0, 255'd1, 255'd1, 255'd0, 255'd1, 1'b0);
    drain("err_clear");

    // en held high: accepted in IDLE, ignored in FIN, accepted again in IDLE
    @(negedge clk);
    Rx = 255'd7; Ry = 255'd9; Rz = 255'd0; en = 1'b1;
    sb.push_back('{255'd0, 255'd0, 1'b1, cyc, 1'b1});
    @(negedge clk);
    @(negedge clk);
    sb.push_back('{255'd0, 255'd0, 1'b1, cyc, 1'b1});
    @(negedge clk);
    en = 1'b0;
    drain("en_in_fin");
    repeat (8) @(negedge clk);

    // Re-request while busy is ignored; only the first operands produce a result
    issue(255'd2, 255'd4, 255'd2, 255'd1, 255'd2, 1'b0);
    repeat (3) @(negedge clk);
    Rx = 255'd5; Ry = 255'd7; Rz = 255'd1; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    drain("busy_ignore");
    repeat (20) @(negedge clk);

    // Leave a nonzero result, then reset in the middle of an inversion
    issue(255'd1, 255'd3, 255'd2, (P + 255'd1) >> 1, (P + 255'd3) >> 1, 1'b0);
    drain("pre_reset");
    issue(255'd0, 255'd1, P - 255'd1, 255'd0, P - 255'd1, 1'b0);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_Px", Px, '0);
    chk("midrst_Py", Py, '0);
    chk("midrst_busy", N'(busy), '0);
    chk("midrst_done", N'(done), '0);
    chk("midrst_err", N'(err), '0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(255'd0, 255'd1, 255'd1, 255'd0, 255'd1, 1'b0);
    drain("post_reset");
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
